// File: rtl/spi_rx_fifo.sv
// Receive-side FIFO behind the SPI slave. It synchronises the slave's done flag
// into clk, writes one word per done rising edge and drains through valid/ready.
module spi_rx_fifo #(
  parameter int DW    = 12,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          done_in,
  input  logic [DW-1:0] dout_in,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overflow,
  input  logic          clr_ovf
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic          sync1, sync2, prev;
  logic          push, pop, wr_en;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0] mem [DEPTH];

  // Preset high so a done already asserted at reset release is not seen as an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= done_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign push    = sync2 & ~prev;
  assign m_valid = (count != '0);
  assign full    = (count == CNT_FULL);
  assign pop     = m_valid & m_ready;
  assign wr_en   = push & (~full | pop);
  assign m_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= dout_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A dropped word outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (push & full & ~pop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Bench for spi_rx_fifo: directed boundary scenarios plus random traffic,
// all checked against a queue-based reference model of the FIFO.
module tb_spi_rx_fifo;
  localparam int DW    = 12;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          done_in = 1'b0;
  logic [DW-1:0] dout_in = '0;
  logic          m_ready = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          m_valid, full, overflow;
  logic [DW-1:0] m_data;
  logic [3:0]    count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_rx_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .done_in  (done_in),
    .dout_in  (dout_in),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .count    (count),
    .full     (full),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: done samples a rising edge two clocks late; queue holds words.
  logic [DW-1:0] mq[$];
  bit m_ovf = 1'b0;
  bit h1 = 1'b1, h2 = 1'b1, h3 = 1'b1;

  always @(posedge clk or negedge rst) begin : model
    bit rise, take;
    if (!rst) begin
      mq.delete();
      m_ovf = 1'b0;
      h1 = 1'b1;
      h2 = 1'b1;
      h3 = 1'b1;
    end else begin
      rise = h2 && !h3;
      take = m_ready && (mq.size() != 0);
      if (rise && mq.size() == DEPTH && !take) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      if (take) void'(mq.pop_front());
      if (rise && mq.size() < DEPTH) mq.push_back(dout_in);
      h3 = h2;
      h2 = h1;
      h1 = done_in;
    end
  end

  always @(negedge clk) begin
    chk("count", count, mq.size());
    chk("m_valid", m_valid, mq.size() != 0);
    chk("full", full, mq.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
    if (mq.size() != 0) chk("m_data", m_data, mq[0]);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [DW-1:0] w);
    dout_in = w;
    done_in = 1'b1;
    tick(3);
    done_in = 1'b0;
    tick(2);
  endtask

  initial begin
    int hold, gap, rdiv;
    hold = 0;
    gap  = 0;

    tick(2);
    chk("rst_count", count, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", m_data, 0);
    rst = 1'b1;
    tick(4);

    // T1: single word latency and show-ahead pop
    m_ready = 1'b1;
    dout_in = 12'hA5C;
    done_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      chk("t1_valid", m_valid, i == 3);
      if (i == 3) chk("t1_data", m_data, 12'hA5C);
    end
    @(negedge clk);
    done_in = 1'b0;
    tick(3);
    chk("t1_count", count, 0);
    m_ready = 1'b0;

    // T2: nine words into eight entries
    for (int w = 1; w <= 9; w++) pulse(DW'(w));
    tick(2);
    chk("t2_count", count, 8);
    chk("t2_full", full, 1);
    chk("t2_ovf", overflow, 1);
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("t2_order", m_data, i);
      tick(1);
    end
    m_ready = 1'b0;
    chk("t2_empty", count, 0);

    // T6: clear, then clear coincident with a dropped word
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    chk("t6_clear", overflow, 0);
    for (int w = 16; w < 24; w++) pulse(DW'(w));
    chk("t6_full", count, 8);
    dout_in = 12'h099;
    done_in = 1'b1;
    tick(2);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    chk("t6_set_wins", overflow, 1);
    tick(1);
    done_in = 1'b0;
    tick(2);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    chk("t6_clear2", overflow, 0);

    // T3: push and pop in the same cycle at full
    dout_in = 12'h0FF;
    done_in = 1'b1;
    tick(2);
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    chk("t3_count", count, 8);
    chk("t3_ovf", overflow, 0);
    tick(1);
    done_in = 1'b0;
    tick(2);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) chk("t3_first", m_data, 12'h011);
      if (i == 7) chk("t3_last", m_data, 12'h0FF);
      tick(1);
    end
    m_ready = 1'b0;

    // T4: long done gives one write
    dout_in = 12'h3C3;
    done_in = 1'b1;
    tick(40);
    done_in = 1'b0;
    tick(3);
    chk("t4_count", count, 1);
    chk("t4_data", m_data, 12'h3C3);
    for (int w = 32; w < 36; w++) pulse(DW'(w));
    chk("t5_pre", count, 5);

    // T5: async reset mid-cycle, release with done high
    #2 rst = 1'b0;
    #1;
    chk("t5_count", count, 0);
    chk("t5_valid", m_valid, 0);
    dout_in = 12'h555;
    done_in = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(5);
    chk("t5_nowrite", count, 0);
    done_in = 1'b0;
    tick(4);
    chk("t5_after", count, 0);

    // Random traffic: slow consumer first to exercise full/overflow, then faster
    for (int c = 0; c < 3000; c++) begin
      rdiv = (c < 1500) ? 7 : 1;
      m_ready = ($urandom_range(0, rdiv) == 0);
      clr_ovf = ($urandom_range(0, 19) == 0);
      if (done_in) begin
        if (hold == 0) begin
          done_in = 1'b0;
          gap = $urandom_range(1, 4);
        end else begin
          hold--;
        end
      end else if (gap > 0) begin
        gap--;
      end else begin
        dout_in = DW'($urandom());
        done_in = 1'b1;
        hold = $urandom_range(2, 6);
      end
      tick(1);
    end
    done_in = 1'b0;
    m_ready = 1'b1;
    clr_ovf = 1'b0;
    tick(20);
    chk("final_empty", count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
